// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS main control unit: opcodes,
// datapath select encodings, fault codes and the registered control word.
// No ports; imported by the controller top.
package multicycle_controller_pkg;

   // Opcode field values decoded by the controller
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // ALUOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;
   localparam logic [1:0] ALUOP_IMM   = 2'd3;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

   // PCSource encodings
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // Fault codes
   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_ILLEGAL = 2'b01;
   localparam logic [1:0] FC_TIMEOUT = 2'b10;

   // Purely state-decoded control word; IRWrite is absent because it is
   // only ever the mem_ready-gated FETCH term.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, datapath
// enables/selects plus fault and debug state out.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
   parameter int OPCODE_WIDTH = 6
);
   logic [OPCODE_WIDTH-1:0] d_c_opcode;
   logic                    mem_ready;
   logic                    PCWrite;
   logic                    PCWriteCond;
   logic                    BranchNe;
   logic                    IorD;
   logic                    MemRead;
   logic                    MemWrite;
   logic                    IRWrite;
   logic                    MemtoReg;
   logic                    RegDst;
   logic                    RegWrite;
   logic                    ALUSrcA;
   logic [1:0]              ALUSrcB;
   logic [1:0]              ALUOp;
   logic [1:0]              PCSource;
   logic                    fault;
   logic [1:0]              fault_code;
   logic [3:0]              state_o;

   modport master (
      input  d_c_opcode, mem_ready,
      output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             fault, fault_code, state_o
   );

   modport slave (
      output d_c_opcode, mem_ready,
      input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             fault, fault_code, state_o
   );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Memory wait timer: counts consecutive not-ready cycles in a waiting state
// and flags timeout when the count reaches MEM_TIMEOUT with mem_ready still 0.
// Ports: clk_i/rst_i, wait_i (in a memory state), mem_ready_i, timeout_o (comb).
module multicycle_controller_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_WIDTH   = $clog2(MEM_TIMEOUT + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic wait_i,
   input  logic mem_ready_i,
   output logic timeout_o
);
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Completion on the same cycle wins, hence the mem_ready_i term.
   assign timeout_o = wait_i && !mem_ready_i && (cnt_q == CNT_WIDTH'(MEM_TIMEOUT));

   // Count only while the FSM stays put waiting; any other cycle leaves the
   // counter at zero, so each entry to a waiting state starts from 0.
   always_comb begin
      cnt_d = '0;
      if (wait_i && !mem_ready_i && !timeout_o) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/mem/wb.
// Latency: controls registered with the state; only IRWrite/PCWrite in FETCH follow mem_ready.
// Backpressure: FETCH/MEMRD/MEMWR stall on mem_ready=0, faulting after MEM_TIMEOUT waits.
// Ports: d_clk, d_rst (sync, active high), bus (master modport: opcode/mem_ready in, controls out).
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int OPCODE_WIDTH = 6,
   parameter int MEM_TIMEOUT  = 15,
   parameter int CNT_WIDTH    = $clog2(MEM_TIMEOUT + 1)
) (
   input logic                     d_clk,
   input logic                     d_rst,
   multicycle_controller_if.master bus
);
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC_R = 4'd7,
      S_RWB    = 4'd8,  S_EXEC_I = 4'd9,  S_IWB    = 4'd10, S_BRANCH = 4'd11,
      S_JUMP   = 4'd12, S_FAULT  = 4'd13
   } state_e;

   function automatic ctrl_t ctrl_of(state_e s, logic is_bne);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; end
         S_DECODE: c.alu_src_b = SRCB_IMM_SL2;
         S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
         S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
         S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
         S_EXEC_R: begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_FUNCT; end
         S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         S_EXEC_I: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_IMM; end
         S_IWB:    c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_B;
            c.alu_op        = ALUOP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
            c.branch_ne     = is_bne;
         end
         S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_e     state_q, state_d;
   ctrl_t      ctrl_q;
   logic       fault_q;
   logic [1:0] fault_code_q, fc_d;
   logic       timeout;

   logic is_lw, is_sw, is_rtype, is_beq, is_bne, is_j, is_imm;
   assign is_lw    = (bus.d_c_opcode == OPCODE_WIDTH'(OP_LW));
   assign is_sw    = (bus.d_c_opcode == OPCODE_WIDTH'(OP_SW));
   assign is_rtype = (bus.d_c_opcode == OPCODE_WIDTH'(OP_RTYPE));
   assign is_beq   = (bus.d_c_opcode == OPCODE_WIDTH'(OP_BEQ));
   assign is_bne   = (bus.d_c_opcode == OPCODE_WIDTH'(OP_BNE));
   assign is_j     = (bus.d_c_opcode == OPCODE_WIDTH'(OP_J));
   assign is_imm   = (bus.d_c_opcode == OPCODE_WIDTH'(OP_ADDI))  ||
                     (bus.d_c_opcode == OPCODE_WIDTH'(OP_ADDIU)) ||
                     (bus.d_c_opcode == OPCODE_WIDTH'(OP_SLTI))  ||
                     (bus.d_c_opcode == OPCODE_WIDTH'(OP_SLTIU)) ||
                     (bus.d_c_opcode == OPCODE_WIDTH'(OP_ANDI))  ||
                     (bus.d_c_opcode == OPCODE_WIDTH'(OP_ORI))   ||
                     (bus.d_c_opcode == OPCODE_WIDTH'(OP_XORI));

   multicycle_controller_mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_mem_wait_timer (
      .clk_i       (d_clk),
      .rst_i       (d_rst),
      .wait_i      ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)),
      .mem_ready_i (bus.mem_ready),
      .timeout_o   (timeout)
   );

   always_comb begin
      state_d = state_q;
      fc_d    = FC_NONE;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH, S_MEMRD, S_MEMWR: begin
            if (bus.mem_ready) begin
               if (state_q == S_FETCH)      state_d = S_DECODE;
               else if (state_q == S_MEMRD) state_d = S_MEMWB;
               else                         state_d = S_FETCH;
            end else if (timeout) begin
               state_d = S_FAULT;
               fc_d    = FC_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (is_lw || is_sw)        state_d = S_MEMADR;
            else if (is_rtype)         state_d = S_EXEC_R;
            else if (is_imm)           state_d = S_EXEC_I;
            else if (is_beq || is_bne) state_d = S_BRANCH;
            else if (is_j)             state_d = S_JUMP;
            else begin
               state_d = S_FAULT;
               fc_d    = FC_ILLEGAL;
            end
         end
         // The IR still holds the opcode here, so LW/SW can be re-decoded.
         S_MEMADR: state_d = is_lw ? S_MEMRD : S_MEMWR;
         S_EXEC_R: state_d = S_RWB;
         S_EXEC_I: state_d = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Controls are decoded from the next state so they line up with state_q.
   always_ff @(posedge d_clk) begin
      if (d_rst) begin
         state_q      <= S_IDLE;
         ctrl_q       <= '0;
         fault_q      <= 1'b0;
         fault_code_q <= FC_NONE;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_of(state_d, is_bne);
         // FAULT is only left through reset, so the first code is kept.
         if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
            fault_q      <= 1'b1;
            fault_code_q <= fc_d;
         end
      end
   end

   logic fetch_done;
   assign fetch_done = (state_q == S_FETCH) && bus.mem_ready;

   assign bus.PCWrite     = ctrl_q.pc_write | fetch_done;
   assign bus.IRWrite     = fetch_done;
   assign bus.PCWriteCond = ctrl_q.pc_write_cond;
   assign bus.BranchNe    = ctrl_q.branch_ne;
   assign bus.IorD        = ctrl_q.iord;
   assign bus.MemRead     = ctrl_q.mem_read;
   assign bus.MemWrite    = ctrl_q.mem_write;
   assign bus.MemtoReg    = ctrl_q.mem_to_reg;
   assign bus.RegDst      = ctrl_q.reg_dst;
   assign bus.RegWrite    = ctrl_q.reg_write;
   assign bus.ALUSrcA     = ctrl_q.alu_src_a;
   assign bus.ALUSrcB     = ctrl_q.alu_src_b;
   assign bus.ALUOp       = ctrl_q.alu_op;
   assign bus.PCSource    = ctrl_q.pc_source;
   assign bus.fault       = fault_q;
   assign bus.fault_code  = fault_code_q;
   assign bus.state_o     = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
   localparam int TO = 15;
   localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                  P_MEMWB = 5, P_MEMWR = 6, P_EXEC_R = 7, P_RWB = 8, P_EXEC_I = 9,
                  P_IWB = 10, P_BRANCH = 11, P_JUMP = 12, P_FAULT = 13;

   logic d_clk = 1'b0;
   logic d_rst;

   multicycle_controller_if #(.OPCODE_WIDTH(6)) bus();

   multicycle_controller #(.OPCODE_WIDTH(6), .MEM_TIMEOUT(TO)) dut (
      .d_clk (d_clk),
      .d_rst (d_rst),
      .bus   (bus)
   );

   always #5 d_clk = ~d_clk;

   typedef struct {
      bit        rst;
      bit [5:0]  op;
      bit        rdy;
      bit        chk;
      int        phase;
      bit [23:0] exp;
   } rec_t;

   rec_t     stim_q[$];
   rec_t     exp_q[$];
   int       n_cmp = 0;
   int       n_bad = 0;
   int       cur   = -1;
   bit [1:0] fcode = 2'b00;
   bit [5:0] legal[13] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                           6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};

   function automatic bit rr();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit [5:0] rnd_op();
      return 6'($urandom);
   endfunction

   function automatic bit is_legal(bit [5:0] op);
      foreach (legal[i]) if (legal[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Expected output word for one cycle, straight from the per-state table.
   function automatic bit [23:0] model(int ph, bit [5:0] op, bit rdy, bit [1:0] fc);
      bit pcw = 0, pcwc = 0, bne = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
      bit m2r = 0, rdst = 0, rw = 0, srca = 0, flt = 0;
      bit [1:0] srcb = 0, aop = 0, pcs = 0, code = 0;
      case (ph)
         P_FETCH:  begin mrd = 1; srcb = 2'd1; irw = rdy; pcw = rdy; end
         P_DECODE: srcb = 2'd3;
         P_MEMADR: begin srca = 1; srcb = 2'd2; end
         P_MEMRD:  begin mrd = 1; iord = 1; end
         P_MEMWB:  begin rw = 1; m2r = 1; end
         P_MEMWR:  begin mwr = 1; iord = 1; end
         P_EXEC_R: begin srca = 1; aop = 2'd2; end
         P_RWB:    begin rw = 1; rdst = 1; end
         P_EXEC_I: begin srca = 1; srcb = 2'd2; aop = 2'd3; end
         P_IWB:    rw = 1;
         P_BRANCH: begin srca = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; bne = (op == 6'h05); end
         P_JUMP:   begin pcw = 1; pcs = 2'd2; end
         P_FAULT:  begin flt = 1; code = fc; end
         default:  ;
      endcase
      return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
              srcb, aop, pcs, flt, code, 4'(ph)};
   endfunction

   task automatic emit(int ph, bit rst, bit [5:0] op, bit rdy);
      rec_t r;
      r.rst   = rst;
      r.op    = op;
      r.rdy   = rdy;
      r.chk   = (ph >= 0);
      r.phase = ph;
      r.exp   = (ph >= 0) ? model(ph, op, rdy, fcode) : 24'h0;
      stim_q.push_back(r);
   endtask

   // w not-ready cycles then a ready one; w > TO means the access never completes.
   task automatic mem_phase(int ph, bit [5:0] op, int w, output bit ok);
      int n;
      n = (w > TO) ? TO + 1 : w;
      for (int i = 0; i < n; i++) emit(ph, 1'b0, (ph == P_FETCH) ? rnd_op() : op, 1'b0);
      if (w > TO) begin
         ok    = 1'b0;
         cur   = P_FAULT;
         fcode = 2'b10;
      end else begin
         emit(ph, 1'b0, (ph == P_FETCH) ? rnd_op() : op, 1'b1);
         ok = 1'b1;
      end
   endtask

   task automatic do_instr(bit [5:0] op, int wf, int wm);
      bit ok;
      mem_phase(P_FETCH, op, wf, ok);
      if (!ok) return;
      emit(P_DECODE, 1'b0, op, rr());
      if (op == 6'h23) begin
         emit(P_MEMADR, 1'b0, op, rr());
         mem_phase(P_MEMRD, op, wm, ok);
         if (!ok) return;
         emit(P_MEMWB, 1'b0, op, rr());
      end else if (op == 6'h2B) begin
         emit(P_MEMADR, 1'b0, op, rr());
         mem_phase(P_MEMWR, op, wm, ok);
         if (!ok) return;
      end else if (op == 6'h00) begin
         emit(P_EXEC_R, 1'b0, op, rr());
         emit(P_RWB, 1'b0, op, rr());
      end else if (op >= 6'h08 && op <= 6'h0E) begin
         emit(P_EXEC_I, 1'b0, op, rr());
         emit(P_IWB, 1'b0, op, rr());
      end else if (op == 6'h04 || op == 6'h05) begin
         emit(P_BRANCH, 1'b0, op, rr());
      end else if (op == 6'h02) begin
         emit(P_JUMP, 1'b0, op, rr());
      end else begin
         cur   = P_FAULT;
         fcode = 2'b01;
         return;
      end
      cur = P_FETCH;
   endtask

   task automatic do_reset();
      emit(cur, 1'b1, rnd_op(), rr());
      emit(P_IDLE, 1'b1, rnd_op(), rr());
      emit(P_IDLE, 1'b0, rnd_op(), rr());
      cur   = P_FETCH;
      fcode = 2'b00;
   endtask

   task automatic settle();
      if (cur == P_FAULT) begin
         for (int i = 0; i < 20; i++) emit(P_FAULT, 1'b0, rnd_op(), rr());
         do_reset();
      end
   endtask

   // LW interrupted by reset while MEMRD is still waiting.
   task automatic abort_lw(int k);
      bit ok;
      mem_phase(P_FETCH, 6'h23, 0, ok);
      emit(P_DECODE, 1'b0, 6'h23, rr());
      emit(P_MEMADR, 1'b0, 6'h23, rr());
      for (int i = 0; i < k; i++) emit(P_MEMRD, 1'b0, 6'h23, 1'b0);
      cur = P_MEMRD;
      do_reset();
   endtask

   function automatic int rnd_wait();
      int r;
      r = $urandom_range(0, 99);
      if (r < 5)  return 16 + $urandom_range(0, 3);
      if (r < 10) return TO;
      if (r < 20) return $urandom_range(4, 14);
      return $urandom_range(0, 3);
   endfunction

   task automatic build();
      bit [5:0] op;
      do_reset();
      do_instr(6'h00, 0, 0);
      do_instr(6'h23, 0, 3);
      do_instr(6'h2B, 0, 0);
      do_instr(6'h05, 0, 0);
      do_instr(6'h04, 0, 0);
      do_instr(6'h02, 0, 0);
      do_instr(6'h3F, 0, 0);  settle();
      do_instr(6'h00, 16, 0); settle();
      do_instr(6'h00, TO, 0);
      do_instr(6'h23, 0, 16); settle();
      do_instr(6'h2B, 1, TO);
      abort_lw(5);
      do_instr(6'h08, 0, 0);
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 99) < 8) begin
            do op = rnd_op(); while (is_legal(op));
         end else begin
            op = legal[$urandom_range(0, 12)];
         end
         if ($urandom_range(0, 49) == 0) abort_lw($urandom_range(0, TO));
         else do_instr(op, rnd_wait(), rnd_wait());
         settle();
      end
   endtask

   // Driver: applies one record per cycle and hands its expectation to the scoreboard.
   initial begin
      rec_t r;
      d_rst          = 1'b1;
      bus.d_c_opcode = 6'h00;
      bus.mem_ready  = 1'b0;
      build();
      while (stim_q.size() > 0) begin
         r = stim_q.pop_front();
         @(posedge d_clk);
         #1;
         d_rst          = r.rst;
         bus.d_c_opcode = r.op;
         bus.mem_ready  = r.rdy;
         exp_q.push_back(r);
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge d_clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Monitor: every falling edge compares the presented outputs with the oldest expectation.
   initial begin
      rec_t        r;
      logic [23:0] act;
      forever begin
         @(negedge d_clk);
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            if (r.chk) begin
               act = {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.IorD, bus.MemRead,
                      bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                      bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.fault,
                      bus.fault_code, bus.state_o};
               n_cmp++;
               if (act !== r.exp) begin
                  n_bad++;
                  $display("FAIL state%0d_outputs t=%0t op=%h rdy=%0d: got %h, expected %h",
                           r.phase, $time, r.op, r.rdy, act, r.exp);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle MIPS main control unit: a Moore FSM that sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over several clocks per instruction, driving datapath enables for one shared ALU and one shared memory port.
- Extends the single-cycle opcode decoder with branch and jump sequencing, a memory-ready handshake with timeout, and sticky fault reporting.
- Sits between the instruction register opcode field and the multicycle datapath muxes and enables.

Parameters:
- OPCODE_WIDTH, 6, width of d_c_opcode.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready in a memory state before fault; must be at least 1.
- CNT_WIDTH, $clog2(MEM_TIMEOUT+1), width of the wait counter (derived).

Ports:
- d_clk  in  1  clock
- d_rst  in  1  synchronous active-high reset
- d_c_opcode  in  OPCODE_WIDTH  opcode from the instruction register
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if the branch condition holds
- BranchNe  out  1  1 selects the BNE sense for PCWriteCond
- IorD  out  1  1: address from ALUOut, 0: from PC
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  1: write-back from MDR
- RegDst  out  1  1: rd, 0: rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  1: register A, 0: PC
- ALUSrcB  out  2  0: B, 1: constant 4, 2: sign-extended immediate, 3: immediate shifted left 2
- ALUOp  out  2  0: add, 1: sub, 2: funct-decoded, 3: opcode-decoded immediate op
- PCSource  out  2  0: ALU result, 1: ALUOut, 2: jump target
- fault  out  1  sticky error flag
- fault_code  out  2  01: illegal opcode, 10: memory timeout
- state_o  out  4  current state, for debug

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, FAULT.
- Reset: a synchronous d_rst forces state=IDLE, counter=0, fault=0, fault_code=0. It overrides every state, including a pending memory wait.
- IDLE: all outputs 0, except state_o, which shows the IDLE encoding. Goes to FETCH on the next clock.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0. IRWrite and PCWrite equal mem_ready; this is the only Mealy gating. Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (computes the branch target).
  - LW goes to MEMADR; SW goes to MEMADR.
  - RTYPE goes to EXEC_R.
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI go to EXEC_I.
  - BEQ/BNE go to BRANCH; J goes to JUMP.
  - Any other opcode goes to FAULT with code 01.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. The opcode is still held by the IR. LW goes to MEMRD, otherwise to MEMWR.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for mem_ready, then goes to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=3. Goes to IWB.
- IWB: RegWrite=1, RegDst=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. BranchNe=1 iff the opcode is BNE. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=2. Goes to FETCH.
- Cycle counts with zero-wait memory: R=4, I=4, LW=5, SW=4, BEQ/BNE=3, J=3.
- Memory wait counter:
  - Cleared on entering FETCH, MEMRD or MEMWR.
  - Increments on each waiting cycle with mem_ready=0.
  - If mem_ready is still 0 when the counter equals MEM_TIMEOUT, the next state is FAULT with code 10.
  - mem_ready=1 on that same cycle completes the access normally; completion wins over timeout.
- FAULT: all datapath outputs 0; fault=1. The state and fault_code are held until d_rst; fault_code records the first fault only.
- Outputs not listed for a state are 0.
- Controls depend only on the state (and on mem_ready in FETCH), so they are glitch-free with respect to d_c_opcode changes outside DECODE, MEMADR and BRANCH.

Decomposition:
- Shared header (header.vh) holds:
  - opcode constants (RTYPE, LOAD, STORE, BEQ, BNE, J and the immediate ALU opcodes);
  - the ALUOp, ALUSrcB and PCSource encodings;
  - the fault codes.
- State encodings are localparams inside this module.
- One sub-module, mem_wait_timer: the counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset then R-type: d_rst=1 for 2 cycles, opcode=6'h00, mem_ready=1 -> states IDLE,FETCH,DECODE,EXEC_R,RWB,FETCH; RegWrite=1 and RegDst=1 only in RWB.
- LW 6'h23 with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles (3 waiting + 1 completing), then MEMWB with MemtoReg=1 and RegWrite=1; no fault.
- SW 6'h2B then BNE 6'h05 -> MemWrite=1 only in MEMWR; BRANCH has PCWriteCond=1, BranchNe=1, PCSource=1; BEQ 6'h04 gives BranchNe=0.
- J 6'h02 -> JUMP asserts PCWrite=1 with PCSource=2, and FETCH follows.
- Illegal opcode 6'h3F -> FAULT, fault=1, fault_code=01 held for 20 cycles; d_rst returns to IDLE with fault=0.
- Timeout: MEM_TIMEOUT=15, mem_ready=0 held in FETCH -> FAULT after the 16th FETCH cycle with code 10. Repeating with mem_ready=1 on that 16th cycle goes to DECODE instead.
